// File: rtl/hazard_ctrl_mc_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl_mc_pkg
//  Brief    : Shared FSM encoding and default constants for the hazard unit.
//  Revision : 1.0 - initial release
// ============================================================================
package hazard_ctrl_mc_pkg;

   localparam int HZ_REG_AW      = 5;
   localparam int HZ_MC_LAT_MDIV = 34;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      MC_BUSY  = 2'd2,
      RMW      = 2'd3
   } hz_state_e;

endpackage
`default_nettype wire

// File: rtl/hazard_ctrl_mc_if.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl_mc_if
//  Brief    : Pipeline-status inputs and enable/bubble outputs of the hazard unit.
//  Revision : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_mc_if
   import hazard_ctrl_mc_pkg::*;
#(
   parameter int REG_AW = HZ_REG_AW,
   parameter int CNT_W  = 32
);
   logic [REG_AW-1:0] id_rs1, id_rs2, ex_rd;
   logic              id_rs1_used, id_rs2_used, id_flush;
   logic              ex_memread, ex_mc_start, ex_mc_done;
   logic              mem_req, mem_ready, mem_store_bh;
   logic              pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
   logic              id_ex_nop, ex_mem_nop, if_id_flush, busy;
   logic [CNT_W-1:0]  stall_cnt;

   modport slave (
      input  id_rs1, id_rs2, ex_rd, id_rs1_used, id_rs2_used, id_flush,
             ex_memread, ex_mc_start, ex_mc_done, mem_req, mem_ready, mem_store_bh,
      output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
             id_ex_nop, ex_mem_nop, if_id_flush, busy, stall_cnt
   );

   modport master (
      output id_rs1, id_rs2, ex_rd, id_rs1_used, id_rs2_used, id_flush,
             ex_memread, ex_mc_start, ex_mc_done, mem_req, mem_ready, mem_store_bh,
      input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
             id_ex_nop, ex_mem_nop, if_id_flush, busy, stall_cnt
   );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl_mc_ldu_cmp.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ldu_cmp
//  Brief    : Combinational load-use comparator between ID sources and EX load.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_ldu_cmp
   import hazard_ctrl_mc_pkg::*;
#(
   parameter int REG_AW = HZ_REG_AW
) (
   input  logic [REG_AW-1:0] ex_rd_i,
   input  logic              ex_memread_i,
   input  logic [REG_AW-1:0] id_rs1_i,
   input  logic              id_rs1_used_i,
   input  logic [REG_AW-1:0] id_rs2_i,
   input  logic              id_rs2_used_i,
   output logic              hazard_o
);
   // x0 is hardwired zero, so a load targeting it never creates a dependency
   assign hazard_o = ex_memread_i && (ex_rd_i != '0) &&
                     (((ex_rd_i == id_rs1_i) && id_rs1_used_i) ||
                      ((ex_rd_i == id_rs2_i) && id_rs2_used_i));
endmodule
`default_nettype wire

// File: rtl/hazard_ctrl_mc.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl_mc
//  Brief    : Stage enables, bubbles and IF/ID flush for the 5-stage RV32 core,
//             covering memory wait, multi-cycle EX, sub-word RMW and load-use.
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl_mc
   import hazard_ctrl_mc_pkg::*;
#(
   parameter int REG_AW    = HZ_REG_AW,
   parameter int MC_LAT    = HZ_MC_LAT_MDIV,
   parameter int EN_BH_RMW = 1,
   parameter int CNT_W     = 32
) (
   input  logic             clk,
   input  logic             rst,
   hazard_ctrl_mc_if.slave  hz
);
   localparam int CW = $clog2(MC_LAT);

   hz_state_e         state_q, state_d;
   logic [CW-1:0]     mc_cnt_q, mc_cnt_d;
   logic [CNT_W-1:0]  stall_cnt_q;
   logic [4:0]        en;        // {pc, if_id, id_ex, ex_mem, mem_wb}
   logic              id_ex_nop, ex_mem_nop;
   logic              ldu_haz, mem_wait, rmw_hit, mc_hit, mc_rel, rmw_en;

   generate
      if (EN_BH_RMW != 0) begin : g_rmw_on
         assign rmw_en = 1'b1;
      end else begin : g_rmw_off
         assign rmw_en = 1'b0;
      end
   endgenerate

   hazard_ldu_cmp #(.REG_AW(REG_AW)) u_ldu_cmp (
      .ex_rd_i       (hz.ex_rd),
      .ex_memread_i  (hz.ex_memread),
      .id_rs1_i      (hz.id_rs1),
      .id_rs1_used_i (hz.id_rs1_used),
      .id_rs2_i      (hz.id_rs2),
      .id_rs2_used_i (hz.id_rs2_used),
      .hazard_o      (ldu_haz)
   );

   assign mem_wait = hz.mem_req & ~hz.mem_ready;
   assign rmw_hit  = hz.mem_req & hz.mem_ready & hz.mem_store_bh & rmw_en;
   assign mc_hit   = hz.ex_mc_start & ~hz.ex_mc_done;
   assign mc_rel   = (mc_cnt_q == '0) | hz.ex_mc_done;

   always_comb begin
      en         = 5'b11111;
      id_ex_nop  = 1'b0;
      ex_mem_nop = 1'b0;
      state_d    = state_q;
      mc_cnt_d   = mc_cnt_q;
      case (state_q)
         RUN, MEM_WAIT: begin
            if ((state_q == MEM_WAIT) && !hz.mem_ready) begin
               en = 5'b00000;
            end else begin
               state_d = RUN;
               if (mem_wait) begin
                  en      = 5'b00000;
                  state_d = MEM_WAIT;
               end else if (rmw_hit) begin
                  en      = 5'b00000;
                  state_d = RMW;
               end else if (mc_hit) begin
                  // EX holds the op while MEM/WB drain behind a bubble
                  en         = 5'b00011;
                  ex_mem_nop = 1'b1;
                  mc_cnt_d   = CW'(MC_LAT - 2);
                  state_d    = MC_BUSY;
               end else if (ldu_haz) begin
                  en        = 5'b00111;
                  id_ex_nop = 1'b1;
               end
            end
         end
         RMW: begin
            en      = 5'b00000;
            state_d = RUN;
         end
         MC_BUSY: begin
            if (mc_cnt_q != '0) mc_cnt_d = mc_cnt_q - CW'(1);
            if (mem_wait) begin
               en = 5'b00000;
            end else if (mc_rel) begin
               state_d = RUN;
            end else begin
               en         = 5'b00011;
               ex_mem_nop = 1'b1;
            end
         end
         default: state_d = RUN;
      endcase
      if (rst) begin
         en         = 5'b11111;
         id_ex_nop  = 1'b0;
         ex_mem_nop = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= RUN;
         mc_cnt_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         mc_cnt_q <= mc_cnt_d;
         if (!en[4] && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
   end

   assign hz.pc_en       = en[4];
   assign hz.if_id_en    = en[3];
   assign hz.id_ex_en    = en[2];
   assign hz.ex_mem_en   = en[1];
   assign hz.mem_wb_en   = en[0];
   assign hz.id_ex_nop   = id_ex_nop;
   assign hz.ex_mem_nop  = ex_mem_nop;
   assign hz.if_id_flush = hz.id_flush & en[3];
   assign hz.busy        = (state_q != RUN);
   assign hz.stall_cnt   = stall_cnt_q;
endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl_mc.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hazard_ctrl_mc
//  Brief    : Directed scoreboard bench for hazard_ctrl_mc (RMW on and off).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl_mc;
   import hazard_ctrl_mc_pkg::*;

   // {pc, if_id, id_ex, ex_mem, mem_wb, id_ex_nop, ex_mem_nop, if_id_flush, busy}
   localparam logic [8:0] NORM     = 9'b111110000;
   localparam logic [8:0] LDU      = 9'b001111000;
   localparam logic [8:0] FLUSH    = 9'b111110010;
   localparam logic [8:0] FRZ_RUN  = 9'b000000000;
   localparam logic [8:0] FRZ_BUSY = 9'b000000001;
   localparam logic [8:0] MC_ENTRY = 9'b000110100;
   localparam logic [8:0] MC_HOLD  = 9'b000110101;
   localparam logic [8:0] REL_BUSY = 9'b111110001;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   string      tag_q[$];
   logic [8:0] exp_q[$];

   always #5 clk = ~clk;

   hazard_ctrl_mc_if #(.REG_AW(5), .CNT_W(32)) ifa ();
   hazard_ctrl_mc_if #(.REG_AW(5), .CNT_W(4))  ifb ();

   assign ifb.id_rs1       = ifa.id_rs1;
   assign ifb.id_rs2       = ifa.id_rs2;
   assign ifb.ex_rd        = ifa.ex_rd;
   assign ifb.id_rs1_used  = ifa.id_rs1_used;
   assign ifb.id_rs2_used  = ifa.id_rs2_used;
   assign ifb.id_flush     = ifa.id_flush;
   assign ifb.ex_memread   = ifa.ex_memread;
   assign ifb.ex_mc_start  = ifa.ex_mc_start;
   assign ifb.ex_mc_done   = ifa.ex_mc_done;
   assign ifb.mem_req      = ifa.mem_req;
   assign ifb.mem_ready    = ifa.mem_ready;
   assign ifb.mem_store_bh = ifa.mem_store_bh;

   hazard_ctrl_mc #(.REG_AW(5), .MC_LAT(34), .EN_BH_RMW(1), .CNT_W(32)) dut_a (
      .clk (clk), .rst (rst), .hz (ifa)
   );
   hazard_ctrl_mc #(.REG_AW(5), .MC_LAT(34), .EN_BH_RMW(0), .CNT_W(4)) dut_b (
      .clk (clk), .rst (rst), .hz (ifb)
   );

   wire [8:0] obs_a = {ifa.pc_en, ifa.if_id_en, ifa.id_ex_en, ifa.ex_mem_en, ifa.mem_wb_en,
                       ifa.id_ex_nop, ifa.ex_mem_nop, ifa.if_id_flush, ifa.busy};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Push expectation, compare on the falling edge, return just after the next rise
   task automatic step(input string tag, input logic [8:0] exp);
      tag_q.push_back(tag);
      exp_q.push_back(exp);
      @(negedge clk);
      chk(tag_q.pop_front(), {23'd0, obs_a}, {23'd0, exp_q.pop_front()});
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ifa.id_rs1 = '0; ifa.id_rs2 = '0; ifa.ex_rd = '0;
      ifa.id_rs1_used = 1'b0; ifa.id_rs2_used = 1'b0; ifa.id_flush = 1'b0;
      ifa.ex_memread = 1'b0; ifa.ex_mc_start = 1'b0; ifa.ex_mc_done = 1'b0;
      ifa.mem_req = 1'b0; ifa.mem_ready = 1'b0; ifa.mem_store_bh = 1'b0;
   endtask

   initial begin
      idle();
      ifa.ex_memread = 1'b1; ifa.ex_rd = 5'd5; ifa.id_rs1 = 5'd5; ifa.id_rs1_used = 1'b1;
      ifa.mem_req = 1'b1;
      step("rst_outputs", NORM);
      chk("rst_cnt", ifa.stall_cnt, 32'd0);

      rst = 1'b0; idle();
      step("idle", NORM);
      chk("idle_cnt", ifa.stall_cnt, 32'd0);

      ifa.ex_memread = 1'b1; ifa.ex_rd = 5'd5; ifa.id_rs1 = 5'd5; ifa.id_rs1_used = 1'b1;
      ifa.id_rs2 = 5'd7; ifa.id_rs2_used = 1'b1;
      step("ldu_rs1", LDU);
      idle();
      step("ldu_one_cycle", NORM);
      chk("ldu_cnt", ifa.stall_cnt, 32'd1);

      ifa.ex_memread = 1'b1; ifa.ex_rd = 5'd6; ifa.id_rs1 = 5'd1; ifa.id_rs1_used = 1'b1;
      ifa.id_rs2 = 5'd6; ifa.id_rs2_used = 1'b1;
      step("ldu_rs2", LDU);
      ifa.id_rs2_used = 1'b0;
      step("ldu_rs2_unused", NORM);

      idle();
      ifa.ex_memread = 1'b1; ifa.id_rs1_used = 1'b1; ifa.id_rs2_used = 1'b1;
      step("ldu_x0", NORM);

      ifa.ex_rd = 5'd5; ifa.id_rs1 = 5'd5; ifa.id_flush = 1'b1;
      step("ldu_beats_flush", LDU);
      ifa.ex_memread = 1'b0;
      step("flush_follows", FLUSH);
      idle();
      chk("ldu_flush_cnt", ifa.stall_cnt, 32'd3);

      ifa.mem_req = 1'b1;
      step("memwait_1", FRZ_RUN);
      step("memwait_2", FRZ_BUSY);
      step("memwait_3", FRZ_BUSY);
      ifa.mem_ready = 1'b1;
      step("mem_ready", REL_BUSY);
      idle();
      step("mem_after", NORM);
      chk("mem_cnt", ifa.stall_cnt, 32'd6);

      ifa.mem_req = 1'b1; ifa.mem_ready = 1'b1; ifa.mem_store_bh = 1'b1;
      step("rmw_entry", FRZ_RUN);
      chk("b_rmw_pc_en", {31'd0, ifb.pc_en}, 32'd1);
      idle();
      step("rmw_frozen", FRZ_BUSY);
      chk("b_rmw_busy", {31'd0, ifb.busy}, 32'd0);
      step("rmw_done", NORM);
      chk("rmw_cnt", ifa.stall_cnt, 32'd8);
      chk("b_rmw_cnt", {28'd0, ifb.stall_cnt}, 32'd6);

      ifa.ex_mc_start = 1'b1;
      step("mc_entry", MC_ENTRY);
      for (int i = 0; i < 32; i++) step("mc_hold", MC_HOLD);
      step("mc_release", REL_BUSY);
      ifa.ex_mc_start = 1'b0;
      step("mc_after", NORM);
      chk("mc_cnt", ifa.stall_cnt, 32'd41);
      chk("b_sat_cnt", {28'd0, ifb.stall_cnt}, 32'd15);

      ifa.ex_mc_start = 1'b1;
      step("eo_entry", MC_ENTRY);
      for (int i = 0; i < 3; i++) step("eo_hold", MC_HOLD);
      ifa.ex_mc_done = 1'b1;
      step("eo_release", REL_BUSY);
      idle();
      step("eo_after", NORM);
      chk("eo_cnt", ifa.stall_cnt, 32'd45);
      chk("b_sat_hold", {28'd0, ifb.stall_cnt}, 32'd15);

      ifa.ex_mc_start = 1'b1;
      step("mcm_entry", MC_ENTRY);
      ifa.mem_req = 1'b1;
      step("mcm_memwait", FRZ_BUSY);
      ifa.mem_req = 1'b0;
      step("mcm_resume", MC_HOLD);
      ifa.ex_mc_done = 1'b1;
      step("mcm_release", REL_BUSY);
      idle();
      step("mcm_after", NORM);
      chk("mcm_cnt", ifa.stall_cnt, 32'd48);

      ifa.ex_mc_start = 1'b1;
      step("rmc_entry", MC_ENTRY);
      step("rmc_hold", MC_HOLD);
      rst = 1'b1;
      step("rst_in_mc", NORM);
      chk("rst_mc_cnt", ifa.stall_cnt, 32'd0);
      chk("b_rst_cnt", {28'd0, ifb.stall_cnt}, 32'd0);
      rst = 1'b0; idle();
      step("post_rst", NORM);

      chk("sb_empty", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
